// File: rtl/fb_swap_pkg.sv
// Shared types and defaults for the frame-buffer swap controller.
package fb_swap_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CLEAR_VAL = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SWAP_WAIT = 2'd1,
    ST_CLEAR     = 2'd2
  } state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding {addr, data} back-buffer writes.
// Read data is taken combinationally from the head entry so a pop can be
// registered into the output stage in the same cycle it is granted.
module fb_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is still taken when the head leaves the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Front/back buffer swap controller: PIO level edges become single-cycle
// back-buffer writes, flips happen only in vblank after pre-swap writes
// drain, and the new back buffer is optionally cleared after each flip.
module fb_swap_ctrl
  import fb_swap_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CLEAR_EN   = 1,
  parameter int CLEAR_VAL  = DEF_CLEAR_VAL
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        pio_bb_we,
  input  logic [ADDR_W-1:0] pio_waddr,
  input  logic [DATA_W-1:0] pio_din,
  input  logic [7:0]        pio_swap,
  input  logic              vblank,
  output logic              fb_we,
  output logic              fb_sel,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              front_sel,
  output logic              busy,
  output logic              overflow
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic              r_we_cur, r_we_prev, r_sw_cur, r_sw_prev;
  logic              w_we_edge, w_swap_edge;
  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_drain_cnt, w_drain_next;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_next;
  logic              r_front_sel, w_front_next;
  logic              r_fb_we, r_overflow;
  logic [ADDR_W-1:0] r_fb_waddr;
  logic [DATA_W-1:0] r_fb_wdata;
  logic              w_pop_allow, w_pop, w_clr_wr;
  logic [ENTRY_W-1:0] w_fifo_dout;
  logic              w_full, w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_unused;

  // Only bit 0 of each PIO export carries meaning.
  assign w_unused = ^{pio_bb_we[7:1], pio_swap[7:1]};

  assign w_we_edge   = r_we_cur & ~r_we_prev;
  assign w_swap_edge = r_sw_cur & ~r_sw_prev;
  assign w_pop       = w_pop_allow && !w_empty;

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (w_we_edge),
    .i_din   ({pio_waddr, pio_din}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Two-stage capture of the PIO levels for rising-edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_we_cur  <= 1'b0;
      r_we_prev <= 1'b0;
      r_sw_cur  <= 1'b0;
      r_sw_prev <= 1'b0;
    end else begin
      r_we_cur  <= pio_bb_we[0];
      r_we_prev <= r_we_cur;
      r_sw_cur  <= pio_swap[0];
      r_sw_prev <= r_sw_cur;
    end
  end

  // Next-state logic: pop gating, drain counting, flip and clear sweep.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_clr_next   = r_clr_addr;
    w_front_next = r_front_sel;
    w_pop_allow  = 1'b0;
    w_clr_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop_allow = 1'b1;
        if (w_swap_edge) begin
          // Entries already queued, minus the one leaving this cycle.
          w_drain_next = w_empty ? w_count : (w_count - CNT_W'(1));
          w_state_next = ST_SWAP_WAIT;
        end
      end
      ST_SWAP_WAIT: begin
        if (r_drain_cnt != '0) begin
          w_pop_allow = 1'b1;
          if (!w_empty) w_drain_next = r_drain_cnt - CNT_W'(1);
        end else if (!r_fb_we && vblank) begin
          w_front_next = ~r_front_sel;
          w_clr_next   = '0;
          w_state_next = (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_clr_wr   = 1'b1;
        w_clr_next = r_clr_addr + ADDR_W'(1);
        if (r_clr_addr == '1) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_clr_addr  <= '0;
      r_front_sel <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      r_clr_addr  <= w_clr_next;
      r_front_sel <= w_front_next;
    end
  end

  // Registered write port and sticky drop flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_fb_we    <= 1'b0;
      r_fb_waddr <= '0;
      r_fb_wdata <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_fb_we <= w_pop || w_clr_wr;
      if (w_clr_wr) begin
        r_fb_waddr <= r_clr_addr;
        r_fb_wdata <= DATA_W'(CLEAR_VAL);
      end else if (w_pop) begin
        r_fb_waddr <= w_fifo_dout[ENTRY_W-1:DATA_W];
        r_fb_wdata <= w_fifo_dout[DATA_W-1:0];
      end
      if (w_we_edge && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign fb_we     = r_fb_we;
  assign fb_waddr  = r_fb_waddr;
  assign fb_wdata  = r_fb_wdata;
  assign front_sel = r_front_sel;
  assign fb_sel    = ~r_front_sel;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
